cdb_arbiter: RTL

- Shares the single common data bus (CDB) among the backend's execution units: ALU, LSU and multiply unit.
- Each unit pushes completed results (physical tag + data) into a private 2-entry queue inside this block.
- Each cycle, a round-robin arbiter selects one non-empty queue and drives its head onto a registered `common_pkg::cdb_t` output.
- That output feeds the dispatch wakeup logic and the physical register file write port.

---
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter: per-unit 2-deep result queues, round-robin CDB broadcast.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package common_pkg;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;
endpackage

module cdb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = common_pkg::CDB_TAG_W,
  parameter int DATA_W  = common_pkg::CDB_DATA_W,
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [NUM_SRC-1:0]               req_valid,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]    req_tag,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_SRC-1:0]               req_ready,
  output common_pkg::cdb_t                 cdb_out,
  output logic [SEL_W-1:0]                 grant_src
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
  localparam logic [SEL_W-1:0] c_last    = SEL_W'(NUM_SRC - 1);
  localparam logic [SEL_W:0]   c_num_src = (SEL_W + 1)'(NUM_SRC);

  logic [NUM_SRC-1:0]             w_enq;
  logic [NUM_SRC-1:0]             w_deq;
  logic [NUM_SRC-1:0]             w_nonempty;
  logic [NUM_SRC-1:0][TAG_W-1:0]  w_head_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] w_head_data;

  logic             w_found;
  logic [SEL_W-1:0] w_win;
  logic [SEL_W:0]   w_scan;
  logic [SEL_W-1:0] w_rr_next;
  logic [SEL_W-1:0] r_rr_ptr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [TAG_W-1:0]  r_tag_mem  [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Readiness looks only at registered occupancy, never at this cycle's grant.
    assign req_ready[i]      = !reset && !flush && (r_count < c_depth);
    assign w_enq[i]          = req_valid[i] && req_ready[i];
    assign w_deq[i]          = w_found && (w_win == SEL_W'(i)) && !flush;
    assign w_nonempty[i]     = (r_count != '0);
    assign w_head_tag[i]     = r_tag_mem[r_rd_ptr];
    assign w_head_data[i]    = r_data_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq[i]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_deq[i]) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_enq[i], w_deq[i]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_enq[i]) begin
        r_tag_mem[r_wr_ptr]  <= req_tag[i];
        r_data_mem[r_wr_ptr] <= req_data[i];
      end
    end
  end

  // First non-empty queue at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (SEL_W + 1)'(k);
      if (w_scan >= c_num_src) w_scan = w_scan - c_num_src;
      if (!w_found && w_nonempty[w_scan[SEL_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_scan[SEL_W-1:0];
      end
    end
  end

  assign w_rr_next = (w_win == c_last) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_out   <= '0;
      grant_src <= '0;
      r_rr_ptr  <= '0;
    end else if (flush) begin
      cdb_out.valid <= 1'b0;
    end else if (w_found) begin
      cdb_out.valid <= 1'b1;
      cdb_out.tag   <= w_head_tag[w_win];
      cdb_out.data  <= w_head_data[w_win];
      grant_src     <= w_win;
      r_rr_ptr      <= w_rr_next;
    end else begin
      cdb_out.valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
